// File: rtl/wb_cdb_arbiter.sv
// Writeback arbiter: drains stale-epoch FU results and forwards one live result per cycle
// onto a registered common data bus using round-robin priority.
`ifndef ROB_W
`define ROB_W 6
`endif
`ifndef PHYS_W
`define PHYS_W 7
`endif

module wb_cdb_arbiter #(
  parameter int unsigned NUM_FU     = 3,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_FU-1:0]            fu_wb_valid,
  output logic [NUM_FU-1:0]            fu_wb_ready,
  input  logic [NUM_FU*32-1:0]         fu_wb_pc,
  input  logic [NUM_FU-1:0]            fu_wb_uses_rd,
  input  logic [NUM_FU*`ROB_W-1:0]     fu_wb_rob_idx,
  input  logic [NUM_FU*`PHYS_W-1:0]    fu_wb_prd_new,
  input  logic [NUM_FU*2-1:0]          fu_wb_epoch,
  input  logic [NUM_FU*32-1:0]         fu_wb_data,
  input  logic [1:0]                   cur_epoch,
  input  logic                         flush,
  output logic                         cdb_valid,
  output logic [31:0]                  cdb_pc,
  output logic                         cdb_uses_rd,
  output logic [`ROB_W-1:0]            cdb_rob_idx,
  output logic [`PHYS_W-1:0]           cdb_prd_new,
  output logic [1:0]                   cdb_epoch,
  output logic [31:0]                  cdb_data,
  output logic [DROP_CNT_W-1:0]        drop_cnt
);

  localparam int unsigned RobW = `ROB_W;
  localparam int unsigned PhysW = `PHYS_W;
  localparam int unsigned IdxW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned CntW = $clog2(NUM_FU + 1);

  logic [NUM_FU-1:0]     stale;
  logic [NUM_FU-1:0]     live;
  logic [NUM_FU-1:0]     grant;
  logic                  grant_found;
  logic [IdxW-1:0]       grant_idx;
  logic [IdxW-1:0]       rr_q, rr_d;
  logic [CntW-1:0]       stale_cnt;
  logic [DROP_CNT_W:0]   drop_sum;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic                  cdb_valid_q;
  logic [31:0]           cdb_pc_q, pc_sel;
  logic                  cdb_uses_rd_q, uses_rd_sel;
  logic [RobW-1:0]       cdb_rob_idx_q, rob_idx_sel;
  logic [PhysW-1:0]      cdb_prd_new_q, prd_new_sel;
  logic [1:0]            cdb_epoch_q, epoch_sel;
  logic [31:0]           cdb_data_q, data_sel;

  // Classification: stale ports drain regardless of flush; live ports compete only without flush.
  always_comb begin
    stale     = '0;
    live      = '0;
    stale_cnt = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      stale[i]  = fu_wb_valid[i] && (fu_wb_epoch[i*2 +: 2] != cur_epoch);
      live[i]   = fu_wb_valid[i] && (fu_wb_epoch[i*2 +: 2] == cur_epoch) && !flush;
      stale_cnt = stale_cnt + CntW'(stale[i]);
    end
  end

  // Round-robin search starting at rr_q, wrapping modulo NUM_FU.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant       = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      idx = (int'(rr_q) + k) % NUM_FU;
      if (!grant_found && live[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IdxW'(idx);
      end
    end
    if (grant_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_found) begin
      rr_d = (grant_idx == IdxW'(NUM_FU - 1)) ? '0 : grant_idx + IdxW'(1);
    end
  end

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + (DROP_CNT_W + 1)'(stale_cnt);
    drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  always_comb begin
    pc_sel      = '0;
    uses_rd_sel = 1'b0;
    rob_idx_sel = '0;
    prd_new_sel = '0;
    epoch_sel   = '0;
    data_sel    = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        pc_sel      = fu_wb_pc[i*32 +: 32];
        uses_rd_sel = fu_wb_uses_rd[i];
        rob_idx_sel = fu_wb_rob_idx[i*RobW +: RobW];
        prd_new_sel = fu_wb_prd_new[i*PhysW +: PhysW];
        epoch_sel   = fu_wb_epoch[i*2 +: 2];
        data_sel    = fu_wb_data[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q          <= '0;
      drop_cnt_q    <= '0;
      cdb_valid_q   <= 1'b0;
      cdb_pc_q      <= '0;
      cdb_uses_rd_q <= 1'b0;
      cdb_rob_idx_q <= '0;
      cdb_prd_new_q <= '0;
      cdb_epoch_q   <= '0;
      cdb_data_q    <= '0;
    end else begin
      rr_q        <= rr_d;
      drop_cnt_q  <= drop_cnt_d;
      cdb_valid_q <= grant_found;
      if (grant_found) begin
        cdb_pc_q      <= pc_sel;
        cdb_uses_rd_q <= uses_rd_sel;
        cdb_rob_idx_q <= rob_idx_sel;
        cdb_prd_new_q <= prd_new_sel;
        cdb_epoch_q   <= epoch_sel;
        cdb_data_q    <= data_sel;
      end
    end
  end

  assign fu_wb_ready = rst_n ? (stale | grant) : '0;
  assign cdb_valid   = cdb_valid_q;
  assign cdb_pc      = cdb_pc_q;
  assign cdb_uses_rd = cdb_uses_rd_q;
  assign cdb_rob_idx = cdb_rob_idx_q;
  assign cdb_prd_new = cdb_prd_new_q;
  assign cdb_epoch   = cdb_epoch_q;
  assign cdb_data    = cdb_data_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
